hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage MIPS core. Detects load-use hazards and drives the main

---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID/EX/MEM hazard inputs and pipeline control outputs for hazard_ctrl.
// The master drives the pipeline observations; the slave (the sequencer) drives the enables.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_jump;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             pipe_en;
  logic             stall;
  logic             ifid_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_opcode, id_rs, id_rt, id_jump, ex_memread, ex_rt, mem_req, mem_ready,
    input  pc_write, ifid_write, pipe_en, stall, ifid_flush, mem_err, stall_count
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, id_jump, ex_memread, ex_rt, mem_req, mem_ready,
    output pc_write, ifid_write, pipe_en, stall, ifid_flush, mem_err, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use bubbles, memory freeze,
// jump flush, sticky memory-timeout flag and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, ERR} state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             mem_err_q, mem_err_d;

  logic uses_rs, uses_rt, lu_haz, freeze;
  logic pc_write, ifid_write, pipe_en, stall, ifid_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (bus.id_opcode)
      6'b000000: begin uses_rs = 1'b1; uses_rt = 1'b1; end
      6'b100011: uses_rs = 1'b1;
      6'b101011: begin uses_rs = 1'b1; uses_rt = 1'b1; end
      6'b001100: uses_rs = 1'b1;
      default: ;
    endcase
  end

  assign lu_haz = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                  ((uses_rs && (bus.id_rs == bus.ex_rt)) ||
                   (uses_rt && (bus.id_rt == bus.ex_rt)));
  assign freeze = bus.mem_req && !bus.mem_ready;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    stall_count_d = stall_count_q;
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    pipe_en       = 1'b0;
    stall         = 1'b0;
    ifid_flush    = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (freeze) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
            if (wait_cnt_d == TIMEOUT_V) begin
              state_d   = ERR;
              mem_err_d = 1'b1;
            end
          end else begin
            wait_cnt_d = '0;
            pipe_en    = 1'b1;
            if (lu_haz) begin
              // Bubble: hold PC and IF/ID, let the load advance out of EX.
              stall = 1'b1;
            end else begin
              pc_write   = 1'b1;
              ifid_write = 1'b1;
              ifid_flush = bus.id_jump;
            end
          end
        end
        ERR: mem_err_d = 1'b1;
        default: state_d = RUN;
      endcase
      if (!pc_write) stall_count_d = sat_inc(stall_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.pipe_en     = pipe_en;
  assign bus.stall       = stall;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_count = stall_count_q;

endmodule
